// File: rtl/pll_ctrl_pkg.sv
// Shared types and helpers for the rPLL reconfiguration sequencer.
// Divider values are natural numbers; the PLL select pins want them inverted.
package pll_ctrl_pkg;

  localparam int SEL_W = 6;

  typedef enum logic [2:0] {
    RST_HOLD,
    WAIT_LOCK,
    STABLE,
    RUN,
    ERR
  } state_e;

  typedef struct packed {
    logic [SEL_W-1:0] idiv;
    logic [SEL_W-1:0] fbdiv;
    logic [SEL_W-1:0] odsel;
  } pll_cfg_t;

  // The rPLL dynamic select pins take the one's complement of the divider value.
  function automatic pll_cfg_t to_dyn(input pll_cfg_t cfg);
    pll_cfg_t dyn;
    dyn.idiv  = ~cfg.idiv;
    dyn.fbdiv = ~cfg.fbdiv;
    dyn.odsel = ~cfg.odsel;
    return dyn;
  endfunction

  function automatic pll_cfg_t make_cfg(input int idiv, input int fbdiv, input int odsel);
    pll_cfg_t cfg;
    cfg.idiv  = SEL_W'(idiv);
    cfg.fbdiv = SEL_W'(fbdiv);
    cfg.odsel = SEL_W'(odsel);
    return cfg;
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pll_reconfig_ctrl_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL LOCK into the board clock domain.
module lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// rPLL sequencer: holds RESET, loads dynamic dividers, qualifies lock, retries on
// timeout and falls back to the default configuration when a request never locks.
module pll_reconfig_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 27000,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRY     = 2,
  parameter int DEF_IDIV      = 0,
  parameter int DEF_FBDIV     = 4,
  parameter int DEF_ODSEL     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [5:0] req_idiv,
  input  logic [5:0] req_fbdiv,
  input  logic [5:0] req_odsel,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  output logic       clk_ok,
  output logic       busy,
  output logic       err,
  output logic       fallback,
  output logic       lock_lost
);

  localparam int RST_W = cnt_width(RST_CYCLES);
  localparam int TO_W  = cnt_width(LOCK_TIMEOUT);
  localparam int STB_W = cnt_width(STABLE_CYCLES);
  localparam int RTY_W = cnt_width(MAX_RETRY);

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  localparam pll_cfg_t DEF_CFG = make_cfg(DEF_IDIV, DEF_FBDIV, DEF_ODSEL);

  state_e           state_q,    state_d;
  pll_cfg_t         cfg_q,      cfg_d;
  logic [RST_W-1:0] rst_cnt_q,  rst_cnt_d;
  logic [TO_W-1:0]  to_cnt_q,   to_cnt_d;
  logic [STB_W-1:0] stb_cnt_q,  stb_cnt_d;
  logic [RTY_W-1:0] retry_q,    retry_d;
  logic             fallback_q, fallback_d;
  logic             lock_lost_q, lock_lost_d;

  logic     lock_s;
  logic     accept;
  pll_cfg_t req_cfg;
  pll_cfg_t dyn_sel;

  lock_sync u_lock_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (pll_lock),
    .sync_out (lock_s)
  );

  assign req_cfg.idiv  = req_idiv;
  assign req_cfg.fbdiv = req_fbdiv;
  assign req_cfg.odsel = req_odsel;

  assign req_ready = (state_q == RUN) || (state_q == ERR);
  assign accept    = req_valid && req_ready;

  // NOTE: every _d variable gets its default before the case, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    rst_cnt_d   = rst_cnt_q;
    to_cnt_d    = to_cnt_q;
    stb_cnt_d   = stb_cnt_q;
    retry_d     = retry_q;
    fallback_d  = fallback_q;
    lock_lost_d = 1'b0;

    case (state_q)
      RST_HOLD: begin
        if (rst_cnt_q >= RST_LAST) begin
          state_d   = WAIT_LOCK;
          rst_cnt_d = '0;
          to_cnt_d  = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end

      WAIT_LOCK: begin
        if (lock_s) begin
          // The lock cycle that ends the wait counts as the first stable cycle.
          state_d   = STABLE;
          stb_cnt_d = STB_W'(1);
        end else if (to_cnt_q >= TO_LAST) begin
          to_cnt_d  = '0;
          rst_cnt_d = '0;
          if (retry_q < RTY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = RST_HOLD;
          end else if (cfg_q != DEF_CFG) begin
            cfg_d      = DEF_CFG;
            fallback_d = 1'b1;
            retry_d    = '0;
            state_d    = RST_HOLD;
          end else begin
            state_d = ERR;
          end
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      STABLE: begin
        if (!lock_s) begin
          state_d  = WAIT_LOCK;
          to_cnt_d = '0;
        end else if (stb_cnt_q >= STB_LAST) begin
          state_d = RUN;
        end else begin
          stb_cnt_d = stb_cnt_q + 1'b1;
        end
      end

      RUN: begin
        if (accept) begin
          cfg_d      = req_cfg;
          fallback_d = 1'b0;
          retry_d    = '0;
          rst_cnt_d  = '0;
          state_d    = RST_HOLD;
        end else if (!lock_s) begin
          state_d     = WAIT_LOCK;
          to_cnt_d    = '0;
          retry_d     = '0;
          lock_lost_d = 1'b1;
        end
      end

      ERR: begin
        if (accept) begin
          cfg_d      = req_cfg;
          fallback_d = 1'b0;
          retry_d    = '0;
          rst_cnt_d  = '0;
          state_d    = RST_HOLD;
        end
      end

      default: begin
        state_d = RST_HOLD;
      end
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RST_HOLD;
      cfg_q       <= DEF_CFG;
      rst_cnt_q   <= '0;
      to_cnt_q    <= '0;
      stb_cnt_q   <= '0;
      retry_q     <= '0;
      fallback_q  <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      rst_cnt_q   <= rst_cnt_d;
      to_cnt_q    <= to_cnt_d;
      stb_cnt_q   <= stb_cnt_d;
      retry_q     <= retry_d;
      fallback_q  <= fallback_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  // Selects follow cfg_q, which only changes on entry to RST_HOLD while RESET is high.
  assign dyn_sel    = to_dyn(cfg_q);
  assign pll_idsel  = dyn_sel.idiv;
  assign pll_fbdsel = dyn_sel.fbdiv;
  assign pll_odsel  = dyn_sel.odsel;

  assign pll_reset  = (state_q == RST_HOLD) || (state_q == ERR);
  assign busy       = (state_q == RST_HOLD) || (state_q == WAIT_LOCK) || (state_q == STABLE);
  assign clk_ok     = (state_q == RUN);
  assign err        = (state_q == ERR);
  assign fallback   = fallback_q;
  assign lock_lost  = lock_lost_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Self-checking bench for pll_reconfig_ctrl with a behavioural rPLL lock model.
module tb_pll_reconfig_ctrl;

  localparam int RST_C   = 4;
  localparam int TO_C    = 100;
  localparam int STB_C   = 8;
  localparam int RETRY_C = 1;
  localparam int SYNC_C  = 2;
  localparam logic [5:0] DEF_ID = 6'd0;
  localparam logic [5:0] DEF_FB = 6'd4;
  localparam logic [5:0] DEF_OD = 6'd4;

  typedef struct {
    logic [5:0] id;
    logic [5:0] fb;
    logic [5:0] od;
    bit         bad;
    int         delay;
    logic [5:0] e_id;
    logic [5:0] e_fb;
    logic [5:0] e_od;
    bit         e_fallback;
    int         e_cycles;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [5:0] req_idiv = '0;
  logic [5:0] req_fbdiv = '0;
  logic [5:0] req_odsel = '0;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
  logic       clk_ok, busy, err, fallback, lock_lost;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  pll_reconfig_ctrl #(
    .RST_CYCLES    (RST_C),
    .LOCK_TIMEOUT  (TO_C),
    .STABLE_CYCLES (STB_C),
    .MAX_RETRY     (RETRY_C)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_idiv   (req_idiv),
    .req_fbdiv  (req_fbdiv),
    .req_odsel  (req_odsel),
    .pll_lock   (pll_lock),
    .pll_reset  (pll_reset),
    .pll_idsel  (pll_idsel),
    .pll_fbdsel (pll_fbdsel),
    .pll_odsel  (pll_odsel),
    .clk_ok     (clk_ok),
    .busy       (busy),
    .err        (err),
    .fallback   (fallback),
    .lock_lost  (lock_lost)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // rPLL model: locks lock_delay cycles after RESET falls unless the loaded config is unlockable.
  logic        dead = 1'b0;
  logic        force_low = 1'b0;
  logic        auto_lock = 1'b0;
  logic        bad_valid = 1'b0;
  logic [17:0] bad_cfg = '0;
  int          lock_delay = 20;
  int          low_cnt = 0;
  int          lock_rise_cyc = 0;
  logic        next_lock;

  assign pll_lock = auto_lock && !force_low && !dead;

  always @(negedge clk) begin
    if (pll_reset) low_cnt = 0;
    else           low_cnt = low_cnt + 1;
    next_lock = !pll_reset && (low_cnt >= lock_delay) &&
                !(bad_valid && ({~pll_idsel, ~pll_fbdsel, ~pll_odsel} == bad_cfg));
    if (next_lock && !auto_lock) lock_rise_cyc = cyc;
    auto_lock = next_lock;
  end

  // Observers: lock_lost pulses, RESET-high cycles, select changes while the PLL runs.
  int          lock_lost_cnt = 0;
  int          reset_hi_cnt = 0;
  int          sel_viol = 0;
  logic        mon_en = 1'b0;
  logic [17:0] prev_sel = '0;

  always @(negedge clk) begin
    if (lock_lost) lock_lost_cnt = lock_lost_cnt + 1;
    if (pll_reset) reset_hi_cnt = reset_hi_cnt + 1;
    if (mon_en && !pll_reset && ({pll_idsel, pll_fbdsel, pll_odsel} !== prev_sel))
      sel_viol = sel_viol + 1;
    prev_sel = {pll_idsel, pll_fbdsel, pll_odsel};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: an attempt that locks takes reset + (delay-1) + sync + stable cycles;
  // an unlockable request burns MAX_RETRY+1 full attempts before the default is tried.
  function automatic vec_t predict(input vec_t v);
    vec_t r = v;
    int   lock_time = RST_C + (v.delay - 1) + SYNC_C + STB_C;
    if (v.bad) begin
      r.e_id       = ~DEF_ID;
      r.e_fb       = ~DEF_FB;
      r.e_od       = ~DEF_OD;
      r.e_fallback = 1'b1;
      r.e_cycles   = (RETRY_C + 1) * (RST_C + TO_C) + lock_time;
    end else begin
      r.e_id       = ~v.id;
      r.e_fb       = ~v.fb;
      r.e_od       = ~v.od;
      r.e_fallback = 1'b0;
      r.e_cycles   = lock_time;
    end
    return r;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, " pll_reset"}, pll_reset, 1);
    check({tag, " busy"}, busy, 1);
    check({tag, " clk_ok"}, clk_ok, 0);
    check({tag, " req_ready"}, req_ready, 0);
    check({tag, " err"}, err, 0);
    check({tag, " fallback"}, fallback, 0);
    check({tag, " lock_lost"}, lock_lost, 0);
    check({tag, " sels"}, {pll_idsel, pll_fbdsel, pll_odsel}, {6'h3F, 6'h3B, 6'h3B});
  endtask

  task automatic assert_reset(input int cycles, input string tag);
    rst       = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check_reset_values(tag);
    repeat (cycles - 1) @(negedge clk);
  endtask

  // Releases rst and follows the default power-up sequence through to clk_ok.
  task automatic release_and_check(input string tag);
    int rel;
    int n;
    lock_delay = 20;
    bad_valid  = 1'b0;
    rst        = 1'b0;
    rel        = cyc;
    n = 1;
    forever begin
      @(negedge clk);
      if (!pll_reset || n > 1000) break;
      n++;
    end
    check({tag, " reset hold cycles"}, n, RST_C);
    n = 0;
    while (!clk_ok && n < 2000) begin @(negedge clk); n++; end
    check({tag, " lock->clk_ok"}, clk_ok ? cyc - lock_rise_cyc : -1, SYNC_C + STB_C);
    check({tag, " release->clk_ok"}, clk_ok ? cyc - rel : -1,
          RST_C + (lock_delay - 1) + SYNC_C + STB_C);
    check({tag, " default sels"}, {pll_idsel, pll_fbdsel, pll_odsel}, {6'h3F, 6'h3B, 6'h3B});
    check({tag, " ready in run"}, {req_ready, busy, fallback}, 3'b100);
  endtask

  task automatic apply_request(input vec_t v, input string tag);
    int acc;
    int n;
    bad_valid  = v.bad;
    bad_cfg    = {v.id, v.fb, v.od};
    lock_delay = v.delay;
    @(negedge clk);
    check({tag, " ready before accept"}, req_ready, 1);
    req_valid = 1'b1;
    req_idiv  = v.id;
    req_fbdiv = v.fb;
    req_odsel = v.od;
    @(posedge clk);
    #1 acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, " accept outputs"}, {req_ready, clk_ok, pll_reset, err, fallback}, 5'b00100);
    check({tag, " requested sels"}, {pll_idsel, pll_fbdsel, pll_odsel}, {~v.id, ~v.fb, ~v.od});
    n = 1;
    forever begin
      @(negedge clk);
      if (!pll_reset || n > 1000) break;
      n++;
    end
    check({tag, " reset hold cycles"}, n, RST_C);
    if (v.bad) begin
      n = 1;
      forever begin
        @(negedge clk);
        if (pll_reset || n > 1000) break;
        n++;
      end
      check({tag, " lock wait window"}, n, TO_C);
    end
    n = 0;
    while (!clk_ok && n < 5000) begin @(negedge clk); n++; end
    check({tag, " accept->clk_ok"}, clk_ok ? cyc - acc : -1, v.e_cycles);
    check({tag, " final sels"}, {pll_idsel, pll_fbdsel, pll_odsel}, {v.e_id, v.e_fb, v.e_od});
    check({tag, " fallback"}, fallback, v.e_fallback);
    check({tag, " run flags"}, {busy, err, req_ready}, 3'b001);
  endtask

  initial begin
    vec_t vecs[3];
    vec_t v;
    int   t_clear;
    int   rel;
    int   n;
    bit   saw_low;

    vecs[0] = '{id: 6'd2, fb: 6'd10, od: 6'd8, bad: 1'b0, delay: 20,
                e_id: 6'h3D, e_fb: 6'h35, e_od: 6'h37, e_fallback: 1'b0, e_cycles: 33};
    vecs[1] = '{id: 6'd5, fb: 6'd7, od: 6'd3, bad: 1'b1, delay: 20,
                e_id: 6'h3F, e_fb: 6'h3B, e_od: 6'h3B, e_fallback: 1'b1, e_cycles: 241};
    vecs[2] = '{id: 6'd1, fb: 6'd3, od: 6'd2, bad: 1'b0, delay: 5,
                e_id: 6'h3E, e_fb: 6'h3C, e_od: 6'h3D, e_fallback: 1'b0, e_cycles: 18};

    // Power-up with a PLL that locks 20 cycles after RESET falls.
    assert_reset(3, "powerup");
    mon_en = 1'b1;
    release_and_check("powerup");

    // Reconfiguration table: good, never-locking (fallback), good after fallback.
    for (int i = 0; i < 3; i++) apply_request(vecs[i], $sformatf("vec%0d", i));

    // Randomized requests against the reference model.
    for (int i = 0; i < 6; i++) begin
      v.id    = 6'($urandom_range(0, 63));
      v.fb    = 6'($urandom_range(0, 63));
      v.od    = 6'($urandom_range(0, 63));
      v.bad   = 1'($urandom_range(0, 1));
      v.delay = $urandom_range(1, 40);
      if ({v.id, v.fb, v.od} == {DEF_ID, DEF_FB, DEF_OD}) v.id = 6'd1;
      apply_request(predict(v), $sformatf("rand%0d", i));
    end

    // One-cycle lock drop while running.
    @(negedge clk);
    lock_lost_cnt = 0;
    reset_hi_cnt  = 0;
    force_low     = 1'b1;
    @(negedge clk);
    force_low = 1'b0;
    t_clear   = cyc;
    n = 0;
    saw_low = 1'b0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (!clk_ok) saw_low = 1'b1;
      if (saw_low && clk_ok) break;
    end
    check("lockdrop clk_ok went low", saw_low, 1);
    check("lockdrop recovery cycles", clk_ok ? cyc - t_clear : -1, SYNC_C + STB_C);
    check("lockdrop lock_lost pulses", lock_lost_cnt, 1);
    check("lockdrop no pll reset", reset_hi_cnt, 0);

    // Drop from RUN, then glitch again while qualifying: the stable count restarts.
    lock_lost_cnt = 0;
    force_low     = 1'b1;
    @(negedge clk);
    force_low = 1'b0;
    repeat (5) @(negedge clk);
    force_low = 1'b1;
    @(negedge clk);
    force_low = 1'b0;
    t_clear   = cyc;
    n = 0;
    while (!clk_ok && n < 200) begin @(negedge clk); n++; end
    check("stable glitch restart cycles", clk_ok ? cyc - t_clear : -1, SYNC_C + STB_C);
    check("stable glitch lock_lost pulses", lock_lost_cnt, 1);

    // rst while a user configuration waits for lock.
    lock_delay = 50;
    bad_valid  = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_idiv  = 6'd3;
    req_fbdiv = 6'd3;
    req_odsel = 6'd3;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (pll_reset && n < 100) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    check("midseq user config waiting", {pll_idsel, pll_reset, busy}, {6'h3C, 1'b0, 1'b1});
    assert_reset(3, "midseq");
    release_and_check("midseq");

    // PLL never locks from power-up: both attempts expire, then ERR.
    dead = 1'b1;
    @(negedge clk);
    assert_reset(3, "dead");
    rst = 1'b0;
    rel = cyc;
    n = 0;
    while (!err && n < 1000) begin @(negedge clk); n++; end
    check("dead release->err", err ? cyc - rel : -1, (RETRY_C + 1) * (RST_C + TO_C));
    check("dead err flags", {err, pll_reset, req_ready, clk_ok, busy, fallback}, 6'b111000);
    check("dead sels", {pll_idsel, pll_fbdsel, pll_odsel}, {6'h3F, 6'h3B, 6'h3B});
    dead = 1'b0;
    apply_request(vecs[0], "after_err");

    check("selects moved while pll running", sel_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_reconfig_ctrl.md
Name: pll_reconfig_ctrl

Overview:
- Sequencer for the Gowin rPLL that generates the logic analyzer sample clock.
- Runs on the 27 MHz board clock, not the PLL output.
- Drives the PLL's RESET and dynamic IDSEL/FBDSEL/ODSEL, so the host can change the sample rate at runtime without a rebuild.
- Handles lock qualification, lock-loss recovery, timeout retry and fallback to a known-good default configuration.

Parameters:
- RST_CYCLES, 16: cycles pll_reset is held high per attempt.
- LOCK_TIMEOUT, 27000: cycles to wait for lock after reset release (1 ms at 27 MHz).
- STABLE_CYCLES, 256: consecutive synced-lock cycles required before clk_ok.
- MAX_RETRY, 2: extra attempts with the same configuration after a timeout.
- DEF_IDIV, 0: default IDIV_SEL.
- DEF_FBDIV, 4: default FBDIV_SEL.
- DEF_ODSEL, 4: default ODIV code (27 -> 135 MHz).

Ports:
- clk  in  1  27 MHz board clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  reconfiguration request.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_idiv  in  6  requested IDIV_SEL (natural value).
- req_fbdiv  in  6  requested FBDIV_SEL (natural value).
- req_odsel  in  6  requested ODIV code (natural value).
- pll_lock  in  1  PLL LOCK; asynchronous to clk.
- pll_reset  out  1  to PLL RESET.
- pll_idsel  out  6  to PLL IDSEL, bitwise-inverted encoding.
- pll_fbdsel  out  6  to PLL FBDSEL, bitwise-inverted encoding.
- pll_odsel  out  6  to PLL ODSEL, bitwise-inverted encoding.
- clk_ok  out  1  PLL output is locked and qualified.
- busy  out  1  sequence in progress.
- err  out  1  default configuration also failed.
- fallback  out  1  sticky; default was substituted for a failed request.
- lock_lost  out  1  one-cycle pulse when lock drops in RUN.

Behaviour:
- Interface contract: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - pll_reset=1; busy=1; clk_ok=0; req_ready=0; err=0; fallback=0; lock_lost=0.
  - Active config = defaults; sel outputs = ~default (idsel 6'h3F, fbdsel 6'h3B, odsel 6'h3B).
  - State RST_HOLD; retry count 0.
- pll_lock passes through a 2-flop synchronizer (lock_s, 2-cycle latency). All decisions use lock_s.
- sel outputs change only on the cycle a config is loaded, which always coincides with pll_reset being high. The selects never move while the PLL is running.
- RST_HOLD:
  - pll_reset=1, busy=1.
  - Counts RST_CYCLES cycles, then goes to WAIT_LOCK.
- WAIT_LOCK:
  - pll_reset=0; timeout counter starts at 0.
  - lock_s=1 -> STABLE.
  - Counter reaches LOCK_TIMEOUT -> timeout handling.
- Timeout handling:
  - retry < MAX_RETRY: retry++, back to RST_HOLD with the same config.
  - Else, if active config != default: load default, fallback=1, retry=0, RST_HOLD.
  - Else: ERR.
- STABLE:
  - Counts consecutive lock_s=1 cycles.
  - lock_s=0 -> WAIT_LOCK with a fresh timeout, no PLL reset.
  - Count reaches STABLE_CYCLES -> RUN.
- RUN:
  - clk_ok=1, busy=0, req_ready=1.
  - lock_s=0 -> lock_lost pulse, clk_ok=0 next cycle, WAIT_LOCK (no reset, retry=0).
- ERR:
  - pll_reset=1, err=1, busy=0, req_ready=1, clk_ok=0.
- Request accept (RUN or ERR only):
  - Next cycle: req fields latched as active config, sel outputs = ~req, pll_reset=1, clk_ok=0, req_ready=0, err=0, retry=0, state RST_HOLD.
  - fallback is cleared on accept.
- req_ready=0 in all other states. The requester holds req_valid; nothing is queued.
- rst mid-sequence: immediate return to reset values and the default power-up sequence, regardless of state.
- Counters are sized $clog2(max+1) and saturate; none wrap.

Decomposition:
- Package pll_ctrl_pkg:
  - state enum {RST_HOLD, WAIT_LOCK, STABLE, RUN, ERR}.
  - pll_cfg_t struct {idiv, fbdiv, odsel}.
  - function to_dyn(pll_cfg_t) returning the inverted sel vectors.
  - Default-config constant builder.
- One sub-module: lock_sync (2-flop synchronizer, reset value 0).

Test Plan:
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, MAX_RETRY=1.
1. Power-up: rst 3 cycles, PLL model raises lock 20 cycles after pll_reset falls -> pll_reset high exactly 4 cycles after rst release; clk_ok rises 10 cycles after pll_lock; sels 3F/3B/3B.
2. Reconfig from RUN: idiv=2, fbdiv=10, odsel=8 -> next cycle req_ready=0, clk_ok=0, pll_reset=1 for 4 cycles; sels 3D/35/37 set while reset high; clk_ok returns after lock.
3. Requested config never locks -> two 100-cycle WAIT_LOCK windows, then sels revert to 3F/3B/3B with fallback=1; clk_ok=1 after default locks.
4. pll_lock tied 0 from power-up -> two attempts, then err=1, pll_reset=1, req_ready=1, clk_ok=0; a subsequent request clears err.
5. In RUN drop pll_lock for 1 cycle -> single lock_lost pulse, clk_ok low, pll_reset stays 0, clk_ok back 10 cycles after lock returns; a glitch inside STABLE restarts the 8-cycle count.
6. Assert rst during WAIT_LOCK of a user config -> all outputs at reset values next cycle; default sequence replays as in scenario 1.
